// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one valid/ready command into an AXI-Lite
// write or read and returns exactly one response, with a timeout guarding against hung slaves.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,

    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,

    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,

    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,

    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,

    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             tmo_abort;
    logic             aw_done;
    logic             w_done;

    // The counter reaches TIMEOUT_CYCLES on the edge where tmo_cnt == TIMEOUT_CYCLES-1.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // A B/R handshake in the same cycle as the timeout takes priority over the abort.
    assign tmo_abort = tmo_hit &&
                       ((state == WR_ADDR_DATA) ||
                        (state == RD_ADDR) ||
                        ((state == WR_RESP) && !i_bvalid) ||
                        ((state == RD_DATA) && !i_rvalid));

    assign aw_done     = !o_awvalid || i_awready;
    assign w_done      = !o_wvalid  || i_wready;
    assign o_cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            o_awvalid     <= 1'b0;
            o_wvalid      <= 1'b0;
            o_bready      <= 1'b0;
            o_arvalid     <= 1'b0;
            o_rready      <= 1'b0;
            o_awaddr      <= '0;
            o_wdata       <= '0;
            o_wstrb       <= '0;
            o_araddr      <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_resp    <= 2'b00;
            o_rsp_timeout <= 1'b0;
        end else if (tmo_abort) begin
            state         <= RESP;
            o_awvalid     <= 1'b0;
            o_wvalid      <= 1'b0;
            o_bready      <= 1'b0;
            o_arvalid     <= 1'b0;
            o_rready      <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_rdata   <= '0;
            o_rsp_resp    <= RESP_SLVERR;
            o_rsp_timeout <= 1'b1;
        end else begin
            if ((state != IDLE) && (state != RESP)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        tmo_cnt <= '0;
                        if (i_cmd_write) begin
                            o_awaddr  <= i_cmd_addr;
                            o_wdata   <= i_cmd_wdata;
                            o_wstrb   <= i_cmd_wstrb;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            state     <= WR_ADDR_DATA;
                        end else begin
                            o_araddr  <= i_cmd_addr;
                            o_arvalid <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end

                // AW and W complete independently; either may finish first.
                WR_ADDR_DATA: begin
                    if (i_awready) begin
                        o_awvalid <= 1'b0;
                    end
                    if (i_wready) begin
                        o_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        o_bready <= 1'b1;
                        state    <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (i_bvalid) begin
                        o_bready      <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_resp    <= i_bresp;
                        o_rsp_timeout <= 1'b0;
                        state         <= RESP;
                    end
                end

                RD_ADDR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (i_rvalid) begin
                        o_rready      <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= i_rdata;
                        o_rsp_resp    <= i_rresp;
                        o_rsp_timeout <= 1'b0;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a small reactive AXI-Lite slave model with per-channel
// wait knobs plus one task per scenario, each comparing DUT outputs against hand-derived values.
module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_timeout;
    logic        o_awvalid;
    logic        i_awready;
    logic [31:0] o_awaddr;
    logic        o_wvalid;
    logic        i_wready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_bvalid;
    logic        o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] o_araddr;
    logic        i_rvalid;
    logic        o_rready;
    logic [1:0]  i_rresp;
    logic [31:0] i_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STROBE_WIDTH  (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_write  (i_cmd_write),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wdata  (i_cmd_wdata),
        .i_cmd_wstrb  (i_cmd_wstrb),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_resp   (o_rsp_resp),
        .o_rsp_timeout(o_rsp_timeout),
        .o_awvalid    (o_awvalid),
        .i_awready    (i_awready),
        .o_awaddr     (o_awaddr),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_wdata      (o_wdata),
        .o_wstrb      (o_wstrb),
        .i_bvalid     (i_bvalid),
        .o_bready     (o_bready),
        .i_bresp      (i_bresp),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .o_araddr     (o_araddr),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .i_rresp      (i_rresp),
        .i_rdata      (i_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model knobs and state; every slave signal changes only on the falling edge.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    bit          ar_never = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] mem [16];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit          aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
    logic [3:0]  w_strb_s;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        i_awready = 0; i_wready = 0; i_arready = 0;
        i_bvalid = 0; i_bresp = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (b_hs) i_bvalid = 0;
                if (ar_hs) begin r_pend = 1; r_cnt = 0; end
                if (r_hs) i_rvalid = 0;
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_s[b]) mem[aw_addr_s[5:2]][8*b +: 8] = w_data_s[8*b +: 8];
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                if (b_pend) begin
                    b_cnt++;
                    if (b_cnt > b_delay) begin i_bvalid = 1; i_bresp = bresp_cfg; b_pend = 0; end
                end
                if (r_pend) begin
                    r_cnt++;
                    if (r_cnt > r_delay) begin
                        i_rvalid = 1; i_rdata = mem[ar_addr_s[5:2]]; i_rresp = 2'b00; r_pend = 0;
                    end
                end
                if (o_awvalid) begin aw_cnt++; i_awready = (aw_cnt > aw_delay); end
                else begin aw_cnt = 0; i_awready = 0; end
                if (o_wvalid) begin w_cnt++; i_wready = (w_cnt > w_delay); end
                else begin w_cnt = 0; i_wready = 0; end
                if (o_arvalid) begin ar_cnt++; i_arready = !ar_never && (ar_cnt > ar_delay); end
                else begin ar_cnt = 0; i_arready = 0; end
                aw_hs = o_awvalid && i_awready;
                if (aw_hs) aw_addr_s = o_awaddr;
                w_hs = o_wvalid && i_wready;
                if (w_hs) begin w_data_s = o_wdata; w_strb_s = o_wstrb; end
                b_hs = i_bvalid && o_bready;
                ar_hs = o_arvalid && i_arready;
                if (ar_hs) ar_addr_s = o_araddr;
                r_hs = i_rvalid && o_rready;
            end
        end
    end

    // Returns at the first falling edge after the command handshake edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output bit ok);
        int tries;
        @(negedge clk);
        i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr;
        i_cmd_wdata = wdata; i_cmd_wstrb = strb;
        ok = 0; tries = 0;
        while (!o_cmd_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        ok = o_cmd_ready;
        if (ok) @(negedge clk);
        i_cmd_valid = 0;
    endtask

    // Latency counted in falling edges after acceptance; -1 if no response appears.
    task automatic wait_rsp(input int start, output int l);
        l = start;
        while (!o_rsp_valid && l < 100) begin
            @(negedge clk);
            l++;
        end
        if (!o_rsp_valid) l = -1;
    endtask

    task automatic release_rsp();
        i_rsp_ready = 1;
        @(negedge clk);
        i_rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_ready: got %b expected 0", o_cmd_ready); end
        n_checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL reset_axi_valids: got %b expected 00000", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready});
        end
        n_checks++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_resp} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL reset_rsp_flags: got %b expected 0000", {o_rsp_valid, o_rsp_timeout, o_rsp_resp});
        end
        n_checks++;
        if ({o_rsp_rdata, o_awaddr, o_araddr} !== 96'h0) begin
            n_fail++; $display("[TB] FAIL reset_regs: got %h %h %h expected zeros", o_rsp_rdata, o_awaddr, o_araddr);
        end
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (o_cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_cmd_ready: got %b expected 1", o_cmd_ready); end
    endtask

    task automatic test_write_read();
        bit ok;
        int lat;
        issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, ok);
        n_checks++;
        if ({o_awvalid, o_wvalid, o_awaddr, o_wdata, o_wstrb} !== {1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF}) begin
            n_fail++; $display("[TB] FAIL wr_aw_w_drive: got %b%b %h %h %h expected 11 00000004 deadbeef f",
                               o_awvalid, o_wvalid, o_awaddr, o_wdata, o_wstrb);
        end
        wait_rsp(1, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d expected 3", lat); end
        n_checks++;
        if ({o_rsp_resp, o_rsp_timeout, o_rsp_rdata} !== {2'b00, 1'b0, 32'h0}) begin
            n_fail++; $display("[TB] FAIL wr_rsp: got %b %b %h expected 00 0 00000000", o_rsp_resp, o_rsp_timeout, o_rsp_rdata);
        end
        release_rsp();
        n_checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL wr_rsp_handshake: got %b%b expected 01", o_rsp_valid, o_cmd_ready);
        end
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, ok);
        n_checks++;
        if ({o_arvalid, o_araddr} !== {1'b1, 32'h4}) begin
            n_fail++; $display("[TB] FAIL rd_ar_drive: got %b %h expected 1 00000004", o_arvalid, o_araddr);
        end
        wait_rsp(1, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
        n_checks++;
        if ({o_rsp_rdata, o_rsp_resp, o_rsp_timeout} !== {32'hDEADBEEF, 2'b00, 1'b0}) begin
            n_fail++; $display("[TB] FAIL rd_rsp: got %h %b %b expected deadbeef 00 0", o_rsp_rdata, o_rsp_resp, o_rsp_timeout);
        end
        release_rsp();
    endtask

    task automatic test_w_stall();
        bit ok;
        int lat;
        int bad;
        w_delay = 5;
        issue(1'b1, 32'h0000_0000, 32'h1234_5678, 4'b0011, ok);
        n_checks++;
        if ({o_awvalid, o_wvalid} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL wstall_start: got %b%b expected 11", o_awvalid, o_wvalid);
        end
        bad = 0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if ({o_awvalid, o_wvalid, o_bready, o_wdata, o_wstrb} !== {3'b010, 32'h12345678, 4'b0011}) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL wstall_hold: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        n_checks++;
        if ({o_wvalid, o_bready} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL wstall_bready: got %b%b expected 01", o_wvalid, o_bready);
        end
        wait_rsp(7, lat);
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("[TB] FAIL wstall_latency: got %0d expected 8", lat); end
        release_rsp();
        w_delay = 0;
    endtask

    task automatic test_read_stall();
        bit ok;
        int lat;
        int bad;
        r_delay = 10;
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, ok);
        wait_rsp(1, lat);
        n_checks++;
        if (lat !== 13) begin n_fail++; $display("[TB] FAIL rstall_latency: got %0d expected 13", lat); end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if ({o_rsp_valid, o_cmd_ready, o_rsp_rdata, o_rsp_resp, o_rsp_timeout} !==
                {2'b10, 32'hDEADBEEF, 2'b00, 1'b0}) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL rstall_rsp_hold: got %0d bad cycles expected 0", bad); end
        release_rsp();
        n_checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL rstall_release: got %b%b expected 01", o_rsp_valid, o_cmd_ready);
        end
        r_delay = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        int lat;
        ar_never = 1;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, ok);
        cnt = 0;
        while (o_arvalid && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt !== 16) begin n_fail++; $display("[TB] FAIL tmo_arvalid_cycles: got %0d expected 16", cnt); end
        n_checks++;
        if ({o_arvalid, o_rready, o_rsp_valid, o_rsp_resp, o_rsp_timeout, o_rsp_rdata} !==
            {3'b001, 2'b10, 1'b1, 32'h0}) begin
            n_fail++; $display("[TB] FAIL tmo_rsp: got %b%b%b %b %b %h expected 001 10 1 00000000",
                               o_arvalid, o_rready, o_rsp_valid, o_rsp_resp, o_rsp_timeout, o_rsp_rdata);
        end
        release_rsp();
        ar_never = 0;
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, ok);
        wait_rsp(1, lat);
        n_checks++;
        if ({ok, lat[7:0], o_rsp_rdata, o_rsp_timeout} !== {1'b1, 8'd3, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("[TB] FAIL tmo_recover: got ok=%b lat=%0d %h %b expected ok=1 lat=3 deadbeef 0",
                               ok, lat, o_rsp_rdata, o_rsp_timeout);
        end
        release_rsp();
    endtask

    task automatic test_bresp_err();
        bit ok;
        int lat;
        bresp_cfg = 2'b11;
        issue(1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'hF, ok);
        wait_rsp(1, lat);
        n_checks++;
        if ({lat[7:0], o_rsp_resp, o_rsp_timeout} !== {8'd3, 2'b11, 1'b0}) begin
            n_fail++; $display("[TB] FAIL bresp_err: got lat=%0d %b %b expected lat=3 11 0", lat, o_rsp_resp, o_rsp_timeout);
        end
        release_rsp();
        bresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        int seen;
        aw_delay = 20;
        w_delay  = 20;
        issue(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'hF, ok);
        n_checks++;
        if (o_awvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_awvalid: got %b expected 1", o_awvalid); end
        rst = 1;
        @(negedge clk);
        n_checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid, o_cmd_ready} !== 7'b0) begin
            n_fail++; $display("[TB] FAIL rstmid_drop: got %b expected 0000000",
                               {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid, o_cmd_ready});
        end
        @(negedge clk);
        rst = 0;
        aw_delay = 0;
        w_delay  = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_rsp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("[TB] FAIL rstmid_no_rsp: got %0d response cycles expected 0", seen); end
        issue(1'b0, 32'h0000_0000, 32'h0, 4'h0, ok);
        wait_rsp(1, lat);
        n_checks++;
        if ({lat[7:0], o_rsp_rdata, o_rsp_resp, o_rsp_timeout} !== {8'd3, 32'h00005678, 2'b00, 1'b0}) begin
            n_fail++; $display("[TB] FAIL rstmid_read: got lat=%0d %h %b %b expected lat=3 00005678 00 0",
                               lat, o_rsp_rdata, o_rsp_resp, o_rsp_timeout);
        end
        release_rsp();
    endtask

    initial begin
        rst = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0;
        i_cmd_wdata = 0; i_cmd_wstrb = 0; i_rsp_ready = 0;
        test_reset();
        test_write_read();
        test_w_stall();
        test_read_stall();
        test_timeout();
        test_bresp_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
